// File: rtl/panel_arranque.sv
// Start-button sequencer: synchronized, debounced press -> one-cycle ARRANQUE pulse with latched MODO.
// Define PANEL_ARRANQUE_FRENO_EN to add the brake interlock (INTENTOS counter, BLOQUEADO lockout, BLOQUEO).
module panel_arranque #(
    parameter int T_FILTRO     = 10,
    parameter int MAX_INTENTOS = 3,
    parameter int N            = 5
) (
    input  logic CLK,
    input  logic REINICIO,
    input  logic BOTON,
    input  logic SELECTOR,
    input  logic FRENO,
    output logic ARRANQUE,
    output logic MODO,
    output logic BLOQUEO
);
    // state     | meaning
    // REPOSO    | idle, waiting for the button
    // FILTRO    | counting consecutive pressed cycles
    // DISPARO   | one-cycle start pulse
    // SOLTAR    | waiting for a filtered release
    // BLOQUEADO | lockout after too many brake-less presses
    typedef enum logic [N-1:0] {
        REPOSO    = N'(1),
        FILTRO    = N'(2),
        DISPARO   = N'(4),
        SOLTAR    = N'(8),
        BLOQUEADO = N'(16)
    } estado_t;

    localparam logic [3:0] CNT_FIN = 4'(T_FILTRO - 1);

    estado_t    estado;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    logic       boton_m, boton_s;
    logic       selector_m, selector_s;

`ifdef PANEL_ARRANQUE_FRENO_EN
    localparam logic [2:0] INT_FIN = 3'(MAX_INTENTOS - 1);

    logic       freno_m, freno_s;
    logic [2:0] intentos;

    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) begin
            freno_m <= 1'b0;
            freno_s <= 1'b0;
        end else begin
            freno_m <= FRENO;
            freno_s <= freno_m;
        end
    end
`else
    localparam int MAX_INTENTOS_UNUSED = MAX_INTENTOS;
    logic freno_unused;
    assign freno_unused = FRENO;
`endif

    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) begin
            boton_m    <= 1'b0;
            boton_s    <= 1'b0;
            selector_m <= 1'b0;
            selector_s <= 1'b0;
        end else begin
            boton_m    <= BOTON;
            boton_s    <= boton_m;
            selector_m <= SELECTOR;
            selector_s <= selector_m;
        end
    end

    // Saturating increment so a corrupted count can never wrap back into range.
    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

    always_ff @(posedge CLK or negedge REINICIO) begin
        if (!REINICIO) begin
            estado   <= REPOSO;
            cnt      <= '0;
            MODO     <= 1'b0;
`ifdef PANEL_ARRANQUE_FRENO_EN
            intentos <= '0;
`endif
        end else begin
            case (estado)
                REPOSO: begin
                    cnt <= '0;
                    if (boton_s) estado <= FILTRO;
                end
                FILTRO: begin
                    if (!boton_s) begin
                        estado <= REPOSO;
                        cnt    <= '0;
                    end else if (cnt < CNT_FIN) begin
                        cnt <= cnt_inc;
                    end else begin
                        cnt <= '0;
`ifdef PANEL_ARRANQUE_FRENO_EN
                        if (freno_s) begin
                            estado   <= DISPARO;
                            MODO     <= selector_s;
                            intentos <= '0;
                        end else begin
                            intentos <= intentos + 3'd1;
                            estado   <= (intentos == INT_FIN) ? BLOQUEADO : SOLTAR;
                        end
`else
                        estado <= DISPARO;
                        MODO   <= selector_s;
`endif
                    end
                end
                DISPARO: begin
                    estado <= SOLTAR;
                    cnt    <= '0;
                end
                SOLTAR: begin
                    if (boton_s) begin
                        cnt <= '0;
                    end else if (cnt >= CNT_FIN) begin
                        estado <= REPOSO;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
`ifdef PANEL_ARRANQUE_FRENO_EN
                BLOQUEADO: estado <= BLOQUEADO;
`endif
                default: begin
                    estado <= REPOSO;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign ARRANQUE = (estado == DISPARO);

`ifdef PANEL_ARRANQUE_FRENO_EN
    assign BLOQUEO = (estado == BLOQUEADO);
`else
    assign BLOQUEO = 1'b0;
`endif

endmodule

// File: tb/tb_panel_arranque.sv
// Bench for panel_arranque: run-length reference model compared every cycle, plus directed literal checks.
module tb_panel_arranque;
    localparam int T    = 10;
    localparam int MAXI = 3;
`ifdef PANEL_ARRANQUE_FRENO_EN
    localparam bit BRAKE_EN = 1'b1;
`else
    localparam bit BRAKE_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic REINICIO = 1'b0;
    logic BOTON = 1'b0, SELECTOR = 1'b0, FRENO = 1'b0;
    logic ARRANQUE, MODO, BLOQUEO;

    int vectors = 0;
    int miscompares = 0;
    int edge_n = 0;
    bit chk_en = 1'b0;
    int dut_pulses = 0, dut_pulse_edge = -1;
    int mdl_pulses = 0, mdl_pulse_edge = -1;

    panel_arranque #(.T_FILTRO(T), .MAX_INTENTOS(MAXI), .N(5)) dut (
        .CLK(CLK), .REINICIO(REINICIO), .BOTON(BOTON), .SELECTOR(SELECTOR),
        .FRENO(FRENO), .ARRANQUE(ARRANQUE), .MODO(MODO), .BLOQUEO(BLOQUEO)
    );

    initial forever #5 CLK = ~CLK;

    // Reference: press accepted after T+1 consecutive synchronized highs, release after T lows.
    typedef enum {ESPERA, PULSO, LIBERA, CERRADO} fase_t;
    fase_t fase = ESPERA;
    int    hi_run = 0, lo_run = 0, tries = 0;
    logic  m_modo = 1'b0;
    logic  qb [2];
    logic  qs [2];
    logic  qf [2];

    task automatic model_reset();
        fase = ESPERA; hi_run = 0; lo_run = 0; tries = 0; m_modo = 1'b0;
        for (int i = 0; i < 2; i++) begin qb[i] = 1'b0; qs[i] = 1'b0; qf[i] = 1'b0; end
    endtask

    task automatic model_step(input logic rb, input logic rs, input logic rf);
        logic b, s, f;
        b = qb[1]; s = qs[1]; f = qf[1];
        qb[1] = qb[0]; qb[0] = rb;
        qs[1] = qs[0]; qs[0] = rs;
        qf[1] = qf[0]; qf[0] = rf;
        case (fase)
            ESPERA: begin
                hi_run = b ? hi_run + 1 : 0;
                if (hi_run == T + 1) begin
                    hi_run = 0; lo_run = 0;
                    if (f || !BRAKE_EN) begin
                        fase = PULSO; m_modo = s; tries = 0;
                    end else begin
                        tries = tries + 1;
                        fase = (tries == MAXI) ? CERRADO : LIBERA;
                    end
                end
            end
            PULSO: begin fase = LIBERA; lo_run = 0; end
            LIBERA: begin
                lo_run = b ? 0 : lo_run + 1;
                if (lo_run == T) begin fase = ESPERA; hi_run = 0; end
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input logic b, input logic s, input logic f);
        BOTON = b; SELECTOR = s; FRENO = f;
        @(posedge CLK);
        edge_n++;
        if (!REINICIO) model_reset();
        else model_step(b, s, f);
        @(negedge CLK);
    endtask

    task automatic do_reset(input int hold);
        #2 REINICIO = 1'b0;
        model_reset();
        repeat (hold) cyc(BOTON, SELECTOR, FRENO);
        #2 REINICIO = 1'b1;
    endtask

    task automatic expect_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic clear_pulses();
        dut_pulses = 0; dut_pulse_edge = -1;
        mdl_pulses = 0; mdl_pulse_edge = -1;
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            vectors++;
            if (ARRANQUE !== (fase == PULSO) || MODO !== m_modo || BLOQUEO !== (fase == CERRADO)) begin
                miscompares++;
                $display("FAIL cycle edge=%0d: dut arr/modo/bloq=%b%b%b, model=%b%b%b", edge_n,
                         ARRANQUE, MODO, BLOQUEO, (fase == PULSO), m_modo, (fase == CERRADO));
            end
            if (ARRANQUE === 1'b1) begin dut_pulses++; dut_pulse_edge = edge_n; end
            if (fase == PULSO) begin mdl_pulses++; mdl_pulse_edge = edge_n; end
        end
    end

    initial begin
        int e0;
        int len;
        logic rb, rs, rf;

        @(negedge CLK);
        model_reset();
        chk_en = 1'b1;
        repeat (3) cyc(1'b1, 1'b1, 1'b1);
        #1;
        expect_int("reset_arranque", ARRANQUE, 0);
        expect_int("reset_modo", MODO, 0);
        expect_int("reset_bloqueo", BLOQUEO, 0);
        REINICIO = 1'b1;
        repeat (4) cyc(1'b0, 1'b0, 1'b0);

        // Stable press with brake: single pulse 12 edges after the first sampled press.
        #1 clear_pulses();
        e0 = edge_n + 1;
        repeat (30) cyc(1'b1, 1'b1, 1'b1);
        #1;
        expect_int("stable_pulses", dut_pulses, 1);
        expect_int("stable_pulse_edge", dut_pulse_edge, e0 + 12);
        expect_int("stable_model_edge", mdl_pulse_edge, e0 + 12);
        expect_int("stable_modo", MODO, 1);
        repeat (15) cyc(1'b0, 1'b1, 1'b1);

        // Bouncing button, then a stable level.
        #1 clear_pulses();
        for (int i = 0; i < 40; i++) cyc((i % 3) == 1, 1'b1, 1'b1);
        #1;
        expect_int("bounce_no_pulse", dut_pulses, 0);
        e0 = edge_n + 1;
        repeat (30) cyc(1'b1, 1'b1, 1'b1);
        #1;
        expect_int("bounce_pulses", dut_pulses, 1);
        expect_int("bounce_pulse_edge", dut_pulse_edge, e0 + 12);
        repeat (15) cyc(1'b0, 1'b1, 1'b1);

        // Mode latched at the firing edge only.
        #1 do_reset(2);
        clear_pulses();
        for (int i = 0; i < 30; i++) cyc(1'b1, i >= 5, 1'b1);
        #1;
        expect_int("modo_latched", MODO, 1);
        for (int i = 0; i < 15; i++) cyc(1'b0, i[0], 1'b1);
        #1;
        expect_int("modo_held", MODO, 1);
        repeat (30) cyc(1'b1, 1'b0, 1'b1);
        #1;
        expect_int("modo_electric", MODO, 0);
        expect_int("modo_pulses", dut_pulses, 2);
        repeat (15) cyc(1'b0, 1'b1, 1'b1);

        // Reset mid-filter with the button held across release.
        #1 clear_pulses();
        repeat (8) cyc(1'b1, 1'b1, 1'b1);
        #1 do_reset(3);
        e0 = edge_n + 1;
        repeat (25) cyc(1'b1, 1'b1, 1'b1);
        #1;
        expect_int("rst_mid_pulses", dut_pulses, 1);
        expect_int("rst_mid_edge", dut_pulse_edge, e0 + 12);
        repeat (15) cyc(1'b0, 1'b1, 1'b1);

`ifdef PANEL_ARRANQUE_FRENO_EN
        // Brake-less presses lead to lockout.
        #1 clear_pulses();
        for (int k = 0; k < 3; k++) begin
            repeat (15) cyc(1'b1, 1'b1, 1'b0);
            repeat (15) cyc(1'b0, 1'b1, 1'b0);
        end
        #1;
        expect_int("lock_bloqueo", BLOQUEO, 1);
        repeat (20) cyc(1'b1, 1'b1, 1'b1);
        #1;
        expect_int("lock_no_pulse", dut_pulses, 0);
        expect_int("lock_held", BLOQUEO, 1);
        do_reset(2);
        #1;
        expect_int("lock_cleared", BLOQUEO, 0);
`else
        // Without the interlock the brake is ignored.
        #1 clear_pulses();
        e0 = edge_n + 1;
        repeat (30) cyc(1'b1, 1'b1, 1'b0);
        #1;
        expect_int("nobrake_pulses", dut_pulses, 1);
        expect_int("nobrake_edge", dut_pulse_edge, e0 + 12);
        expect_int("nobrake_bloqueo", BLOQUEO, 0);
`endif
        repeat (15) cyc(1'b0, 1'b1, 1'b1);

        // Random segments of held levels with occasional resets.
        for (int seg = 0; seg < 200; seg++) begin
            rb = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 3) != 0);
            rs = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 30);
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 7) == 0) rs = ~rs;
                if ($urandom_range(0, 15) == 0) rf = ~rf;
                cyc(rb, rs, rf);
            end
            if ($urandom_range(0, 9) == 0) begin
                do_reset($urandom_range(1, 3));
                cyc(BOTON, SELECTOR, FRENO);
            end
        end

        #1 chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
